// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   N_PORTS  : number of requesters (0 = instruction fetch, 1 = load/store)
//   mem_req_t: one request as seen on the shared memory port (default widths)
//   mem_rsp_t: one response word (default widths)
//   rr_pick  : round-robin choice between eligible ports
package mem_arb_pkg;

  localparam int N_PORTS  = 2;
  localparam int PKG_ADDR_W = 21;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_MASK_W = PKG_DATA_W / 8;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic                  wen;
    logic [PKG_DATA_W-1:0] wdata;
    logic [PKG_MASK_W-1:0] wmask;
  } mem_req_t;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] data;
  } mem_rsp_t;

  // One-hot grant. On a tie the port that did not win last time is chosen;
  // 'last' is the index of the most recently granted port.
  function automatic logic [N_PORTS-1:0] rr_pick(input logic [N_PORTS-1:0] elig,
                                                 input logic               last);
    if (elig == 2'b11) begin
      rr_pick = last ? 2'b01 : 2'b10;
    end else begin
      rr_pick = elig;
    end
  endfunction

endpackage

// File: rtl/mem_rsp_slot.sv
// Single-entry response register with valid/ready handshake.
//   clk, reset   : clock, asynchronous active-low reset
//   load         : port granted this cycle; capture load_data
//   load_data    : memory read data (pre-write contents)
//   rs_ready     : consumer takes the held response
//   rs_valid     : response held
//   rs_data      : held response word, stable while rs_valid & !rs_ready
module mem_rsp_slot
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  rs_ready,
  output logic                  rs_valid,
  output logic [DATA_WIDTH-1:0] rs_data
);

  // A load in the same cycle as a drain wins, so a port can issue every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_valid <= 1'b0;
      rs_data  <= '0;
    end else if (load) begin
      rs_valid <= 1'b1;
      rs_data  <= load_data;
    end else if (rs_ready) begin
      rs_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the combinational-read / masked-write data port of the memory
// between instruction fetch (port 0) and load/store (port 1).
//   clk, reset            : clock, asynchronous active-low reset
//   rq_valid/rq_ready     : request handshake; ready is the same-cycle grant
//   rq_addr/wen/wdata/wmask : request payload per port
//   rs_valid/rs_ready     : response handshake, one cycle after the grant
//   rs_data               : read data; for writes, the word before the write
//   mem_addr/wdata/wmask/wen, mem_rdata : shared memory port
//   conflict_cnt          : saturating count of cycles where one port was stalled by the other
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 21,
  parameter  int DATA_WIDTH = 32,
  parameter  int CNT_WIDTH  = 16,
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS-1:0]    rq_valid,
  output logic [N_PORTS-1:0]    rq_ready,
  input  logic [ADDR_WIDTH-1:0] rq_addr  [N_PORTS],
  input  logic [N_PORTS-1:0]    rq_wen,
  input  logic [DATA_WIDTH-1:0] rq_wdata [N_PORTS],
  input  logic [MASK_WIDTH-1:0] rq_wmask [N_PORTS],
  output logic [N_PORTS-1:0]    rs_valid,
  input  logic [N_PORTS-1:0]    rs_ready,
  output logic [DATA_WIDTH-1:0] rs_data  [N_PORTS],
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  output logic                  mem_wen,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (v == '1) ? v : v + 1'b1;
  endfunction

  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] grant;
  logic               last_grant;
  logic               sel;
  logic               conflict;

  // A port may issue only if its response slot is empty or being drained now.
  assign elig = rq_valid & (~rs_valid | rs_ready);

  // Nothing is granted while reset is asserted, so no write can reach memory.
  assign grant    = reset ? rr_pick(elig, last_grant) : '0;
  assign rq_ready = grant;
  assign sel      = grant[1];

  // Port 0 drives the memory when idle; mem_wen keeps that harmless.
  assign mem_addr  = rq_addr[sel];
  assign mem_wdata = rq_wdata[sel];
  assign mem_wmask = rq_wmask[sel];
  assign mem_wen   = (|grant) & rq_wen[sel];

  // Both ports wanted the memory and were able to take it, only one got it.
  assign conflict = (&rq_valid) & (&elig) & (^grant);

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      if (|grant) begin
        last_grant <= sel;
      end
      if (conflict) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

  // Response slots: mem_rdata is captured on the granting edge, before the
  // memory applies any write, so writes return the old word.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_slot
    mem_rsp_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (grant[i]),
      .load_data(mem_rdata),
      .rs_ready (rs_ready[i]),
      .rs_valid (rs_valid[i]),
      .rs_data  (rs_data[i])
    );
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_ready;
  logic [20:0] rq_addr  [2];
  logic [1:0]  rq_wen;
  logic [31:0] rq_wdata [2];
  logic [3:0]  rq_wmask [2];
  logic [1:0]  rs_valid;
  logic [1:0]  rs_ready;
  logic [31:0] rs_data  [2];
  logic [20:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wen;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .rq_valid    (rq_valid),
    .rq_ready    (rq_ready),
    .rq_addr     (rq_addr),
    .rq_wen      (rq_wen),
    .rq_wdata    (rq_wdata),
    .rq_wmask    (rq_wmask),
    .rs_valid    (rs_valid),
    .rs_ready    (rs_ready),
    .rs_data     (rs_data),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_wen     (mem_wen),
    .conflict_cnt(conflict_cnt)
  );

  // Word-addressed memory model: async read, byte-masked write on posedge.
  logic        preload;
  logic [31:0] mem [0:1023];

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (preload) begin
      mem[10'h010] <= 32'h0123_4567;  // 0x040
      mem[10'h040] <= 32'hDEAD_BEEF;  // 0x100
      mem[10'h080] <= 32'hCAFE_F00D;  // 0x200
    end else if (mem_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  wen;
    logic [1:0]  rdy;
    logic [20:0] a0;
    logic [20:0] a1;
    logic [31:0] wd1;
    logic [3:0]  wm1;
    logic [1:0]  e_gnt;
    logic        e_mwen;
    logic [1:0]  e_rsv;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  initial begin
    // rst v      wen    rdy    a0        a1        wd1            wm1    gnt    mwen  rsv    d0             d1             cnt
    // reset held with both requesting, then release: port 0 first
    vq.push_back('{1'b0, 2'b11, 2'b00, 2'b11, 21'h040, 21'h100, 32'h0,         4'h0, 2'b00, 1'b0, 2'b00, 32'h0,         32'h0,         16'd0});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h040, 21'h100, 32'h0,         4'h0, 2'b01, 1'b0, 2'b01, 32'h0123_4567, 32'h0,         16'd1});
    // single read, write returning old word, read back merged word
    vq.push_back('{1'b1, 2'b10, 2'b00, 2'b11, 21'h040, 21'h100, 32'h0,         4'h0, 2'b10, 1'b0, 2'b10, 32'h0123_4567, 32'hDEAD_BEEF, 16'd1});
    vq.push_back('{1'b1, 2'b10, 2'b10, 2'b11, 21'h040, 21'h100, 32'h1122_3344, 4'h5, 2'b10, 1'b1, 2'b10, 32'h0123_4567, 32'hDEAD_BEEF, 16'd1});
    vq.push_back('{1'b1, 2'b10, 2'b00, 2'b11, 21'h040, 21'h100, 32'h0,         4'h0, 2'b10, 1'b0, 2'b10, 32'h0123_4567, 32'hDE22_BE44, 16'd1});
    // zero-mask write still granted, memory unchanged
    vq.push_back('{1'b1, 2'b10, 2'b10, 2'b11, 21'h040, 21'h200, 32'hFFFF_FFFF, 4'h0, 2'b10, 1'b1, 2'b10, 32'h0123_4567, 32'hCAFE_F00D, 16'd1});
    vq.push_back('{1'b1, 2'b10, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b10, 1'b0, 2'b10, 32'h0123_4567, 32'hCAFE_F00D, 16'd1});
    // fresh reset, then six contended cycles
    vq.push_back('{1'b0, 2'b00, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b00, 1'b0, 2'b00, 32'h0,         32'h0,         16'd0});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b01, 1'b0, 2'b01, 32'h0123_4567, 32'h0,         16'd1});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b10, 1'b0, 2'b10, 32'h0123_4567, 32'hCAFE_F00D, 16'd2});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b01, 1'b0, 2'b01, 32'h0123_4567, 32'hCAFE_F00D, 16'd3});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b10, 1'b0, 2'b10, 32'h0123_4567, 32'hCAFE_F00D, 16'd4});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b01, 1'b0, 2'b01, 32'h0123_4567, 32'hCAFE_F00D, 16'd5});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h040, 21'h200, 32'h0,         4'h0, 2'b10, 1'b0, 2'b10, 32'h0123_4567, 32'hCAFE_F00D, 16'd6});
    // backpressure on port 0: stalled slot holds, port 1 runs every cycle
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b10, 21'h040, 21'h200, 32'h0,         4'h0, 2'b01, 1'b0, 2'b01, 32'h0123_4567, 32'hCAFE_F00D, 16'd7});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b10, 21'h100, 21'h200, 32'h0,         4'h0, 2'b10, 1'b0, 2'b11, 32'h0123_4567, 32'hCAFE_F00D, 16'd7});
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b10, 21'h100, 21'h200, 32'h0,         4'h0, 2'b10, 1'b0, 2'b11, 32'h0123_4567, 32'hCAFE_F00D, 16'd7});
    // ready raised: port 0 re-granted in the same cycle
    vq.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 21'h100, 21'h200, 32'h0,         4'h0, 2'b01, 1'b0, 2'b01, 32'hDE22_BE44, 32'hCAFE_F00D, 16'd8});
    // leave a response pending in port 1 for the mid-op reset
    vq.push_back('{1'b1, 2'b10, 2'b00, 2'b11, 21'h100, 21'h100, 32'h0,         4'h0, 2'b10, 1'b0, 2'b10, 32'hDE22_BE44, 32'hDE22_BE44, 16'd8});

    preload     = 1'b1;
    reset       = 1'b0;
    rq_valid    = 2'b00;
    rq_wen      = 2'b00;
    rs_ready    = 2'b00;
    rq_addr[0]  = '0;
    rq_addr[1]  = '0;
    rq_wdata[0] = '0;
    rq_wdata[1] = '0;
    rq_wmask[0] = '0;
    rq_wmask[1] = '0;
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      reset       = vq[i].rst;
      rq_valid    = vq[i].v;
      rq_wen      = vq[i].wen;
      rs_ready    = vq[i].rdy;
      rq_addr[0]  = vq[i].a0;
      rq_addr[1]  = vq[i].a1;
      rq_wdata[1] = vq[i].wd1;
      rq_wmask[1] = vq[i].wm1;
      #1;
      chk($sformatf("v%0d rq_ready", i), 32'(rq_ready), 32'(vq[i].e_gnt));
      chk($sformatf("v%0d mem_wen", i), 32'(mem_wen), 32'(vq[i].e_mwen));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rs_valid", i), 32'(rs_valid), 32'(vq[i].e_rsv));
      chk($sformatf("v%0d rs_data0", i), rs_data[0], vq[i].e_d0);
      chk($sformatf("v%0d rs_data1", i), rs_data[1], vq[i].e_d1);
      chk($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vq[i].e_cnt));
      @(negedge clk);
    end

    // Reset asserted with a response pending and a write presented.
    reset       = 1'b0;
    rq_valid    = 2'b10;
    rq_wen      = 2'b10;
    rs_ready    = 2'b00;
    rq_addr[1]  = 21'h100;
    rq_wdata[1] = 32'h0;
    rq_wmask[1] = 4'hF;
    #1;
    chk("midrst rs_valid async", 32'(rs_valid), 32'h0);
    chk("midrst rq_ready", 32'(rq_ready), 32'h0);
    chk("midrst mem_wen", 32'(mem_wen), 32'h0);
    chk("midrst conflict_cnt", 32'(conflict_cnt), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst mem unchanged", mem[10'h040], 32'hDE22_BE44);
    chk("midrst rs_valid held", 32'(rs_valid), 32'h0);
    @(negedge clk);

    // Normal operation after release.
    reset    = 1'b1;
    rq_valid = 2'b10;
    rq_wen   = 2'b00;
    rs_ready = 2'b11;
    #1;
    chk("post rq_ready", 32'(rq_ready), 32'h2);
    @(posedge clk);
    #1;
    chk("post rs_valid", 32'(rs_valid), 32'h2);
    chk("post rs_data1", rs_data[1], 32'hDE22_BE44);
    @(negedge clk);
    rq_valid = 2'b00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
